// File: rtl/rvb_xperm_pkg.sv
// Shared definitions for the xperm permutation unit: op codes, FSM states and sizing helpers.
// Latency: none (package only).
// Backpressure: not applicable.
package rvb_xperm_pkg;

   localparam logic [1:0] OP_NIB  = 2'b00;
   localparam logic [1:0] OP_BYTE = 2'b01;
   localparam logic [1:0] OP_HALF = 2'b10;
   localparam logic [1:0] OP_WORD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // log2 of the element size in bits: nibble=2, byte=3, half=4, word=5
   function automatic int sz_log2(input logic [1:0] op);
      return int'(op) + 2;
   endfunction

   // number of BUSY cycles needed to resolve all elements, never less than one
   function automatic int chunks(input logic [1:0] op, input int xlen, input int lanes);
      int n;
      int c;
      n = xlen >> sz_log2(op);
      c = (n + lanes - 1) / lanes;
      if (c < 1) c = 1;
      return c;
   endfunction

endpackage

// File: rtl/rvb_xperm_lane.sv
// One crossbar lane: picks element idx of rs1 at a fixed element size, zero when idx is out of range.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module rvb_xperm_lane #(
   parameter int XLEN = 32,
   parameter int SZ   = 4
) (
   input  logic [XLEN-1:0] rs1,
   input  logic [SZ-1:0]   idx,
   output logic [SZ-1:0]   elem
);
   localparam int N = XLEN / SZ;

   // compare the whole index against every legal position, so a large index can never wrap into range
   always_comb begin
      elem = '0;
      for (int j = 0; j < N; j++) begin
         if (idx == SZ'(j)) elem = rs1[j*SZ +: SZ];
      end
   end

endmodule

// File: rtl/rvb_xperm_seq.sv
// Multi-cycle xperm.n/b/h/w unit resolving LANES elements per cycle; RVB_XPERM_WIDE_EN builds half/word support.
// Latency: result valid C = ceil(N/LANES) cycles after acceptance; one op in flight, new accept only from IDLE.
// Backpressure: result held in DONE until out_ready; kill drops the op, in_ready low while busy or holding.
module rvb_xperm_seq
   import rvb_xperm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int LANES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_op,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_res,
   output logic            out_err
);
`ifdef RVB_XPERM_WIDE_EN
   localparam int NSZ = 4;
`else
   localparam int NSZ = 2;
`endif
   localparam int CW = 5;

   state_t          state, state_n;
   logic [XLEN-1:0] rs1_q, rs2_q, acc, chunk_val;
   logic [1:0]      op_q;
   logic [CW-1:0]   cnt, last_cnt;
   logic            accept, step, last, bad_op;
   logic [XLEN-1:0] con [NSZ][LANES];

`ifdef RVB_XPERM_WIDE_EN
   assign bad_op = 1'b0;
`else
   // without the wide lanes, half/word ops are flagged instead of computed
   assign bad_op = op_q[1];
`endif

   assign last_cnt = CW'(chunks(op_q, XLEN, LANES) - 1);

   // one lane set per element size; each lane handles element cnt*LANES+l of the current chunk
   genvar s, l;
   for (s = 0; s < NSZ; s++) begin : g_sz
      localparam int SZ = 4 << s;
      localparam int N  = XLEN / SZ;
      for (l = 0; l < LANES; l++) begin : g_lane
         logic [15:0]   e;
         logic [SZ-1:0] idx, elem;
         assign e   = 16'(cnt) * 16'(LANES) + 16'(l);
         assign idx = SZ'(rs2_q >> (e * 16'(SZ)));
         rvb_xperm_lane #(.XLEN(XLEN), .SZ(SZ)) u_lane (
            .rs1  (rs1_q),
            .idx  (idx),
            .elem (elem)
         );
         assign con[s][l] = (e < 16'(N)) ? (XLEN'(elem) << (e * 16'(SZ))) : '0;
      end
   end

   // merge this cycle's lane outputs for the active element size
   always_comb begin
      chunk_val = '0;
      for (int ll = 0; ll < LANES; ll++) begin
         for (int ss = 0; ss < NSZ; ss++) begin
            if (int'(op_q) == ss) chunk_val = chunk_val | con[ss][ll];
         end
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // next state, handshake outputs and datapath strobes
   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid && !kill) begin
               accept  = 1'b1;
               state_n = BUSY;
            end
         end
         BUSY: begin
            if (kill) begin
               state_n = IDLE;
            end else begin
               step = 1'b1;
               if (cnt == last_cnt || bad_op) begin
                  last    = 1'b1;
                  state_n = DONE;
               end
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (kill || out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // operand capture, chunk accumulation and result load on the final chunk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs1_q   <= '0;
         rs2_q   <= '0;
         op_q    <= '0;
         cnt     <= '0;
         acc     <= '0;
         out_res <= '0;
         out_err <= 1'b0;
      end else if (accept) begin
         rs1_q <= in_rs1;
         rs2_q <= in_rs2;
         op_q  <= in_op;
         cnt   <= '0;
         acc   <= '0;
      end else if (step) begin
         cnt <= cnt + 1'b1;
         acc <= acc | chunk_val;
         if (last) begin
            out_res <= bad_op ? '0 : (acc | chunk_val);
            out_err <= bad_op;
         end
      end
   end

endmodule

// File: tb/tb_rvb_xperm_seq.sv
// Randomized and directed bench for rvb_xperm_seq (XLEN 32, LANES 2) against a behavioural model.
// Latency: expects result C = ceil(N/2) cycles after acceptance, 1 for unsupported ops.
// Backpressure: exercises held out_ready, kill and mid-op reset.
module tb_rvb_xperm_seq;
   localparam int XLEN  = 32;
   localparam int LANES = 2;
`ifdef RVB_XPERM_WIDE_EN
   localparam bit WIDE = 1'b1;
`else
   localparam bit WIDE = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [1:0]      in_op = 2'b00;
   logic [XLEN-1:0] in_rs1 = '0;
   logic [XLEN-1:0] in_rs2 = '0;
   logic            kill = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] out_res;
   logic            out_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rvb_xperm_seq #(.XLEN(XLEN), .LANES(LANES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .kill      (kill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_err   (out_err)
   );

   // reference: each element looks up rs1 by index, zero when idx*sz reaches XLEN
   function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned sz, n, idx, r, mask;
      if (!WIDE && op[1]) return 32'h0;
      sz   = 64'd4 << op;
      n    = 64'd32 / sz;
      mask = (64'd1 << sz) - 64'd1;
      r    = 0;
      for (longint unsigned i = 0; i < n; i++) begin
         idx = (64'(b) >> (i * sz)) & mask;
         if (idx * sz < 64'd32) r = r | (((64'(a) >> (idx * sz)) & mask) << (i * sz));
      end
      return 32'(r);
   endfunction

   function automatic logic ref_err(input logic [1:0] op);
      return !WIDE && op[1];
   endfunction

   function automatic int ref_lat(input logic [1:0] op);
      int n;
      if (!WIDE && op[1]) return 1;
      n = 32 / (4 << op);
      return (n + LANES - 1) / LANES;
   endfunction

   // drive one request, wait for its result, then consume it
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic err, output int lat);
      int w;
      @(negedge clk);
      in_op = op; in_rs1 = a; in_rs2 = b; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 64) begin @(negedge clk); lat++; end
      res = out_res;
      err = out_err;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_res !== 32'h0 || out_err !== 1'b0) begin
         bad++;
         $display("FAIL reset: in_ready=%b out_valid=%b out_res=%h out_err=%b, want 1 0 00000000 0",
                  in_ready, out_valid, out_res, out_err);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_directed();
      logic [1:0]  ops [6]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
      logic [31:0] as  [6]  = '{32'h76543210, 32'h76543210, 32'h44332211, 32'h44332211, 32'hBEEFCAFE, 32'h13579BDF};
      logic [31:0] bs  [6]  = '{32'h01234567, 32'h89ABCDEF, 32'h00010203, 32'h04000000, 32'h0000FFFF, 32'h00000000};
      logic [31:0] res;
      logic        err;
      int          lat;
      for (int t = 0; t < 6; t++) begin
         do_op(ops[t], as[t], bs[t], res, err, lat);
         total++;
         if (res !== ref_res(ops[t], as[t], bs[t]) || err !== ref_err(ops[t]) || lat != ref_lat(ops[t])) begin
            bad++;
            $display("FAIL directed_%0d: res=%h err=%b lat=%0d, want res=%h err=%b lat=%0d",
                     t, res, err, lat, ref_res(ops[t], as[t], bs[t]), ref_err(ops[t]), ref_lat(ops[t]));
         end
      end
      // literal spot checks for the always-supported ops
      do_op(2'b00, 32'h76543210, 32'h01234567, res, err, lat);
      total++;
      if (res !== 32'h01234567 || lat != 4) begin
         bad++;
         $display("FAIL nibble_literal: res=%h lat=%0d, want 01234567 lat=4", res, lat);
      end
      do_op(2'b01, 32'h44332211, 32'h00010203, res, err, lat);
      total++;
      if (res !== 32'h11223344 || lat != 2) begin
         bad++;
         $display("FAIL byte_literal: res=%h lat=%0d, want 11223344 lat=2", res, lat);
      end
      do_op(2'b01, 32'h44332211, 32'h04000000, res, err, lat);
      total++;
      if (res !== 32'h00111111) begin
         bad++;
         $display("FAIL byte_oob_literal: res=%h, want 00111111", res);
      end
   endtask

   task automatic test_accum_clear();
      logic [31:0] res;
      logic        err;
      int          lat;
      do_op(2'b00, 32'hFFFFFFFF, 32'h00000000, res, err, lat);
      total++;
      if (res !== 32'hFFFFFFFF) begin
         bad++;
         $display("FAIL accum_fill: res=%h, want ffffffff", res);
      end
      do_op(2'b00, 32'h76543210, 32'h89ABCDEF, res, err, lat);
      total++;
      if (res !== 32'h00000000) begin
         bad++;
         $display("FAIL accum_clear: res=%h, want 00000000", res);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a, b, expv;
      int          w;
      a = 32'hBEEFCAFE; b = 32'h0000FFFF;
      expv = ref_res(2'b10, a, b);
      @(negedge clk);
      in_op = 2'b10; in_rs1 = a; in_rs2 = b; in_valid = 1'b1; out_ready = 1'b0;
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 64) begin @(negedge clk); w++; end
      total++;
      if (w != 1) begin
         bad++;
         $display("FAIL bp_latency: lat=%0d, want 1", w);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_res !== expv || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold_%0d: valid=%b res=%h in_ready=%b, want 1 %h 0", c, out_valid, out_res, in_ready, expv);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_release: valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_kill();
      logic [31:0] res;
      logic        err;
      int          lat, w;
      bit          seen;
      @(negedge clk);
      in_op = 2'b00; in_rs1 = $urandom; in_rs2 = $urandom; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      @(posedge clk);
      @(negedge clk);           // first BUSY cycle
      in_valid = 1'b0;
      @(negedge clk);           // second BUSY cycle
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL kill_busy: valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
      seen = 1'b0;
      repeat (8) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL kill_no_result: out_valid seen=1, want 0");
      end
      // kill in IDLE blocks a simultaneous request
      in_valid = 1'b1; kill = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; kill = 1'b0;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL kill_idle: in_ready=%b, want 1", in_ready);
      end
      seen = 1'b0;
      repeat (8) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL kill_idle_no_result: out_valid seen=1, want 0");
      end
      do_op(2'b01, 32'h44332211, 32'h00010203, res, err, lat);
      total++;
      if (res !== 32'h11223344 || lat != 2) begin
         bad++;
         $display("FAIL after_kill: res=%h lat=%0d, want 11223344 lat=2", res, lat);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res;
      logic        err;
      int          lat, w;
      bit          seen;
      do_op(2'b00, 32'h76543210, 32'h01234567, res, err, lat);
      @(negedge clk);
      in_op = 2'b00; in_rs1 = 32'hFEDCBA98; in_rs2 = 32'h01234567; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_res !== 32'h0 || out_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: in_ready=%b out_valid=%b out_res=%h out_err=%b, want 1 0 00000000 0",
                  in_ready, out_valid, out_res, out_err);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL reset_mid_no_result: out_valid seen=1, want 0");
      end
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a, b, res;
      logic        err;
      int          lat;
      for (int t = 0; t < 40; t++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 1) == 1) b = b & 32'h03030303;
         do_op(op, a, b, res, err, lat);
         total++;
         if (res !== ref_res(op, a, b) || err !== ref_err(op) || lat != ref_lat(op)) begin
            bad++;
            $display("FAIL random_%0d op=%0d rs1=%h rs2=%h: res=%h err=%b lat=%0d, want res=%h err=%b lat=%0d",
                     t, op, a, b, res, err, lat, ref_res(op, a, b), ref_err(op), ref_lat(op));
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_accum_clear();
      test_backpressure();
      test_kill();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
